pipelined_alu_shifter: RTL and testbench
========================================

Name: pipelined_alu_shifter

Overview:
- Parametrised, two-stage pipelined ARM data-processing unit: barrel shifter in stage 1, ALU in stage 2, plus an architectural NZCV flag register.
- Generalised successor of the combinational ALU/shifter. Adds:
  - WIDTH parameter
  - register-specified shift amounts (0..255)
  - RRX
  - correct ADC/SBC/RSC carry-in and V flag
  - valid/ready handshakes
  - flag-hazard interlock
- Sits between operand fetch/decode and register writeback in the cpu datapath.

Parameters:
WIDTH, 32, datapath width in bits (power of two, >= 8)
SHAMT_W, 8, shift-amount field width (register-specified amounts use Rs[7:0])

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous, active-low reset
in_valid  input  1  operation presented
in_ready  output  1  unit accepts operation this cycle
opcode  input  4  ARM data-processing opcode (AND..MVN, standard encoding)
s_bit  input  1  S bit; forced to 1 internally for TST/TEQ/CMP/CMN
op_a  input  WIDTH  Rn value
op_b  input  WIDTH  Rm value, or already-rotated immediate
shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR
shift_amt  input  SHAMT_W  shift amount
shift_by_reg  input  1  1 = amount from register; 0 = 5-bit immediate encoding
imm_carry  input  1  carry-out of the rotated immediate
imm_valid  input  1  op_b is an immediate: skip shift, shifter C = imm_carry
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
result  output  WIDTH  ALU result
write_rd  output  1  0 for TST/TEQ/CMP/CMN, else 1
nzcv  output  4  committed flags {N,Z,C,V}

Behaviour:
- Reset (reset_n low at clock edge) takes priority over all other activity. Required state after reset:
  - both stage valids 0
  - out_valid 0
  - result 0
  - write_rd 0
  - nzcv 4'b0000
  - any in-flight operations discarded
- Stage 1 register (S1):
  - Loads on in_valid && in_ready.
  - Captures the shifted operand, shifter carry, op_a, opcode, and the effective S bit.
- Stage 2 register (S2):
  - Loads from S1 when S1 is valid and (S2 is empty or out_ready is high).
  - result, write_rd and out_valid are driven directly from S2.
- Latency: 2 cycles from acceptance to out_valid with no stalls. Throughput: 1 per cycle.
- in_ready is high when S1 is empty, or S1 will advance this cycle, AND no flag hazard is present.
- Flag hazard: S1 holds a valid op with effective S=1. While it holds, in_ready=0 for one cycle, because stage-1 carry-in must see the updated C.
- NZCV commits when an S=1 op moves S1->S2:
  - N = result MSB; Z = (result == 0).
  - C: for logical ops (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN) = shifter carry. For arithmetic ops = adder carry-out, where subtraction C is NOT borrow.
  - V: arithmetic only = signed overflow; logical ops leave V unchanged.
- Shifter carry-in (Cin) is the committed nzcv C at S1 load.
- Shift rules, amount n, width W:
  - imm_valid: result = op_b; C = imm_carry.
  - shift_by_reg, n=0 (any type): result = op_b; C = Cin.
  - LSL: for 1<=n<W, normal shift, C = b[W-n]. n=W: result 0, C = b[0]. n>W: result 0, C = 0.
  - LSR: for 1<=n<W, normal shift, C = b[n-1]. n=W: result 0, C = b[W-1]. n>W: result 0, C = 0.
  - ASR: n>=W gives all sign bits, C = b[W-1].
  - ROR by register: uses n mod W. If n != 0 and n mod W == 0: result = b, C = b[W-1].
  - Immediate encoding: LSL #0 = no shift, C = Cin. LSR #0 and ASR #0 mean n = W. ROR #0 is RRX: {Cin, b[W-1:1]}, C = b[0].
- Arithmetic, all WIDTH-bit modulo (Cf = committed C):
  - SUB/CMP = a + ~b + 1
  - RSB = b + ~a + 1
  - ADC = a + b + Cf
  - SBC = a + ~b + Cf
  - RSC = b + ~a + Cf
  - MVN = ~b (shifted operand)
- Backpressure: with out_ready low, S2 holds result steady. S1 may fill; in_ready then drops until S2 drains.
- Simultaneous S2 drain and S1 advance in the same cycle is legal and loses no data.

Test Plan:
- Reset: hold reset_n low 2 cycles mid-stream -> out_valid=0, result=0, nzcv=0000, no stale result appears after release.
- ADDS 0x7FFFFFFF + 0x00000001 -> result 0x80000000, out_valid 2 cycles after accept, nzcv=1001; then SUBS 5-5 -> 0x00000000, nzcv=0110.
- MOVS op_b=0x80000000 with register-specified LSR, shift_amt=32 -> result 0, C=1; shift_amt=33 -> result 0, C=0; immediate ROR #0 with C=1 on op_b=0x00000001 -> 0x80000000, C=1.
- Hazard: ADDS 0xFFFFFFFF+1 (sets C=1) back-to-back with ADC 0+0 -> in_ready low exactly 1 cycle, ADC result 0x00000001.
- Backpressure: 3 ops streamed, out_ready low 4 cycles -> result holds op1, in_ready drops once S1 is full, all 3 results emerge in order with no duplicates.
- CMP 3,7 -> write_rd=0, nzcv=1000; TST 0xF0 & 0x0F with LSL #4 (shifter C=0) -> Z=1, C=0, V unchanged.

Source files
------------

// File: rtl/pipelined_alu_shifter_if.sv
// Operand/result bus of the pipelined ALU/shifter: operation request with
// valid/ready, result stream with valid/ready, and the committed flags.
interface pipelined_alu_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         opcode;
  logic               s_bit;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [1:0]         shift_type;
  logic [SHAMT_W-1:0] shift_amt;
  logic               shift_by_reg;
  logic               imm_carry;
  logic               imm_valid;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               write_rd;
  logic [3:0]         nzcv;

  // Datapath side
  modport slave (
    input  in_valid, opcode, s_bit, op_a, op_b, shift_type, shift_amt,
           shift_by_reg, imm_carry, imm_valid, out_ready,
    output in_ready, out_valid, result, write_rd, nzcv
  );

  // Decode / writeback side
  modport master (
    output in_valid, opcode, s_bit, op_a, op_b, shift_type, shift_amt,
           shift_by_reg, imm_carry, imm_valid, out_ready,
    input  in_ready, out_valid, result, write_rd, nzcv
  );
endinterface

// File: rtl/pipelined_alu_shifter.sv
// Two-stage ARM data-processing unit: barrel shifter in stage 1, ALU and
// NZCV commit in stage 2. Ops that set flags block the next acceptance for
// one cycle so the following shifter/ALU carry-in sees the committed C.
module pipelined_alu_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  pipelined_alu_shifter_if.slave bus
);
  localparam int LW = $clog2(WIDTH);

  // Stage 1 state
  logic             s1_valid_r;
  logic [WIDTH-1:0] s1_opnd_r;
  logic             s1_shc_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [3:0]       s1_op_r;
  logic             s1_s_r;

  // Stage 2 state and architectural flags
  logic             s2_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             write_rd_r;
  logic [3:0]       nzcv_r;

  // Handshake
  logic s2_adv_s;
  logic in_ready_s;
  logic accept_s;
  logic s_eff_s;

  // Shifter
  logic [31:0]      n_s;
  logic [LW-1:0]    m_s;
  logic [WIDTH:0]   wide_s;
  logic [WIDTH-1:0] sh_res_s;
  logic             sh_c_s;

  // ALU
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;
  logic             ci_s;
  logic             arith_s;
  logic [WIDTH-1:0] logic_res_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] alu_res_s;
  logic [3:0]       nzcv_next_s;

  assign s2_adv_s   = s1_valid_r && (!s2_valid_r || bus.out_ready);
  assign in_ready_s = !s1_valid_r || (s2_adv_s && !s1_s_r);
  assign accept_s   = bus.in_valid && in_ready_s;
  assign s_eff_s    = bus.s_bit || (bus.opcode[3:2] == 2'b10);

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.result    = result_r;
  assign bus.write_rd  = write_rd_r;
  assign bus.nzcv      = nzcv_r;

  // Barrel shifter: produce shifted operand and shifter carry from the inputs
  always_comb begin
    n_s      = bus.shift_by_reg ? 32'(bus.shift_amt) : 32'(bus.shift_amt[4:0]);
    m_s      = '0;
    wide_s   = '0;
    sh_res_s = bus.op_b;
    sh_c_s   = nzcv_r[1];
    // Immediate LSR #0 / ASR #0 encode a full-width shift
    if (!bus.shift_by_reg && n_s == 32'd0 &&
        (bus.shift_type == 2'b01 || bus.shift_type == 2'b10)) begin
      n_s = 32'(WIDTH);
    end else begin
      n_s = n_s;
    end
    if (bus.imm_valid) begin
      sh_res_s = bus.op_b;
      sh_c_s   = bus.imm_carry;
    end else if (n_s == 32'd0) begin
      if (!bus.shift_by_reg && bus.shift_type == 2'b11) begin
        // RRX
        sh_res_s = {nzcv_r[1], bus.op_b[WIDTH-1:1]};
        sh_c_s   = bus.op_b[0];
      end else begin
        sh_res_s = bus.op_b;
        sh_c_s   = nzcv_r[1];
      end
    end else begin
      case (bus.shift_type)
        2'b00: begin
          // Extra MSB catches the last bit shifted out, also for n == WIDTH
          wide_s             = {1'b0, bus.op_b} << n_s;
          {sh_c_s, sh_res_s} = wide_s;
        end
        2'b01: begin
          wide_s             = {bus.op_b, 1'b0} >> n_s;
          {sh_res_s, sh_c_s} = wide_s;
        end
        2'b10: begin
          // Arithmetic shift saturates to sign bits for any n >= WIDTH
          wide_s             = $signed({bus.op_b, 1'b0}) >>> n_s;
          {sh_res_s, sh_c_s} = wide_s;
        end
        2'b11: begin
          m_s      = n_s[LW-1:0];
          sh_res_s = (bus.op_b >> m_s) | (bus.op_b << (32'(WIDTH) - 32'(m_s)));
          sh_c_s   = sh_res_s[WIDTH-1];
        end
        default: begin
          sh_res_s = bus.op_b;
          sh_c_s   = nzcv_r[1];
        end
      endcase
    end
  end

  // ALU: operate on stage-1 contents and compute the flags to commit
  always_comb begin
    x_s         = s1_a_r;
    y_s         = s1_opnd_r;
    ci_s        = 1'b0;
    arith_s     = 1'b0;
    logic_res_s = '0;
    case (s1_op_r)
      4'h0, 4'h8: logic_res_s = s1_a_r & s1_opnd_r;
      4'h1, 4'h9: logic_res_s = s1_a_r ^ s1_opnd_r;
      4'hC:       logic_res_s = s1_a_r | s1_opnd_r;
      4'hD:       logic_res_s = s1_opnd_r;
      4'hE:       logic_res_s = s1_a_r & ~s1_opnd_r;
      4'hF:       logic_res_s = ~s1_opnd_r;
      4'h2, 4'hA: begin arith_s = 1'b1; y_s = ~s1_opnd_r; ci_s = 1'b1; end
      4'h3: begin arith_s = 1'b1; x_s = s1_opnd_r; y_s = ~s1_a_r; ci_s = 1'b1; end
      4'h4, 4'hB: begin arith_s = 1'b1; ci_s = 1'b0; end
      4'h5: begin arith_s = 1'b1; ci_s = nzcv_r[1]; end
      4'h6: begin arith_s = 1'b1; y_s = ~s1_opnd_r; ci_s = nzcv_r[1]; end
      4'h7: begin arith_s = 1'b1; x_s = s1_opnd_r; y_s = ~s1_a_r; ci_s = nzcv_r[1]; end
      default: logic_res_s = '0;
    endcase
    sum_s = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, ci_s};
    if (arith_s) begin
      alu_res_s      = sum_s[WIDTH-1:0];
      nzcv_next_s[1] = sum_s[WIDTH];
      nzcv_next_s[0] = (x_s[WIDTH-1] == y_s[WIDTH-1]) &&
                       (sum_s[WIDTH-1] != x_s[WIDTH-1]);
    end else begin
      alu_res_s      = logic_res_s;
      nzcv_next_s[1] = s1_shc_r;
      nzcv_next_s[0] = nzcv_r[0];
    end
    nzcv_next_s[3] = alu_res_s[WIDTH-1];
    nzcv_next_s[2] = (alu_res_s == '0);
  end

  // Stage 1 register: capture the shifted operand on acceptance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s1_opnd_r  <= '0;
      s1_shc_r   <= 1'b0;
      s1_a_r     <= '0;
      s1_op_r    <= 4'h0;
      s1_s_r     <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_opnd_r  <= sh_res_s;
      s1_shc_r   <= sh_c_s;
      s1_a_r     <= bus.op_a;
      s1_op_r    <= bus.opcode;
      s1_s_r     <= s_eff_s;
    end else if (s2_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2 register and flag commit when an op moves out of stage 1
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= '0;
      write_rd_r <= 1'b0;
      nzcv_r     <= 4'b0000;
    end else if (s2_adv_s) begin
      s2_valid_r <= 1'b1;
      result_r   <= alu_res_s;
      write_rd_r <= (s1_op_r[3:2] != 2'b10);
      if (s1_s_r) begin
        nzcv_r <= nzcv_next_s;
      end else begin
        nzcv_r <= nzcv_r;
      end
    end else if (s2_valid_r && bus.out_ready) begin
      s2_valid_r <= 1'b0;
    end else begin
      s2_valid_r <= s2_valid_r;
    end
  end
endmodule

// File: tb/tb_pipelined_alu_shifter.sv
// Self-checking bench for pipelined_alu_shifter: directed scenarios plus a
// randomized stream scored against a program-order reference model.
module tb_pipelined_alu_shifter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;

  pipelined_alu_shifter_if #(.WIDTH(W), .SHAMT_W(8)) bus();
  pipelined_alu_shifter #(.WIDTH(W), .SHAMT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        wr;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t       sbq[$];
  logic [3:0] mflags;
  int         checks = 0;
  int         errors = 0;
  int         drains = 0;
  bit         rand_bp = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Shifter rules written out bit by bit
  function automatic void mshift(input logic [31:0] b, input logic [1:0] st,
                                 input logic [7:0] amt, input bit byreg, input bit imm,
                                 input bit icarry, input bit cin,
                                 output logic [31:0] r, output bit c);
    int n, m;
    r = b; c = cin;
    if (imm) begin c = icarry; return; end
    n = byreg ? int'(amt) : int'(amt[4:0]);
    if (!byreg && n == 0) begin
      if (st == 2'b11) begin r = {cin, b[31:1]}; c = b[0]; return; end
      if (st == 2'b01 || st == 2'b10) n = 32;
    end
    if (n == 0) return;
    r = '0;
    case (st)
      2'b00: begin
        for (int i = 0; i < 32; i++) if (i - n >= 0) r[i] = b[i-n];
        if (n <= 32) c = b[32-n]; else c = 1'b0;
      end
      2'b01: begin
        for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? b[i+n] : 1'b0;
        if (n <= 32) c = b[n-1]; else c = 1'b0;
      end
      2'b10: begin
        for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? b[i+n] : b[31];
        if (n >= 32) c = b[31]; else c = b[n-1];
      end
      default: begin
        m = n % 32;
        for (int i = 0; i < 32; i++) r[i] = b[(i+m)%32];
        c = (m == 0) ? b[31] : b[m-1];
      end
    endcase
  endfunction

  // One operation in program order, updating the model flags
  function automatic void model_op(input logic [3:0] op, input bit s, input logic [31:0] a,
                                   input logic [31:0] b, input logic [1:0] st,
                                   input logic [7:0] amt, input bit byreg, input bit imm,
                                   input bit icarry, inout logic [3:0] fl,
                                   output logic [31:0] res, output bit wr);
    logic [31:0] sb, x, y;
    bit sc, ci, arith, cnew, vnew, seff;
    longint usum, ssum;
    mshift(b, st, amt, byreg, imm, icarry, fl[1], sb, sc);
    seff = s || (op >= 4'd8 && op <= 4'd11);
    wr = !(op >= 4'd8 && op <= 4'd11);
    arith = 1'b1; x = a; y = sb; ci = 1'b0; res = '0;
    case (op)
      4'd2, 4'd10: begin y = ~sb; ci = 1'b1; end
      4'd3:        begin x = sb; y = ~a; ci = 1'b1; end
      4'd4, 4'd11: ci = 1'b0;
      4'd5:        ci = fl[1];
      4'd6:        begin y = ~sb; ci = fl[1]; end
      4'd7:        begin x = sb; y = ~a; ci = fl[1]; end
      4'd0, 4'd8:  begin arith = 1'b0; res = a & sb; end
      4'd1, 4'd9:  begin arith = 1'b0; res = a ^ sb; end
      4'd12:       begin arith = 1'b0; res = a | sb; end
      4'd13:       begin arith = 1'b0; res = sb; end
      4'd14:       begin arith = 1'b0; res = a & ~sb; end
      default:     begin arith = 1'b0; res = ~sb; end
    endcase
    if (arith) begin
      usum = longint'({32'd0, x}) + longint'({32'd0, y}) + longint'(ci);
      ssum = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      res  = usum[31:0];
      cnew = (usum >= 64'sh1_0000_0000);
      vnew = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
    end else begin
      cnew = sc;
      vnew = fl[0];
    end
    if (seff) fl = {res[31], res == 32'd0, cnew, vnew};
  endfunction

  task automatic tick(output bit acc);
    bit drn;
    exp_t e;
    logic [31:0] r;
    bit w;
    #1;
    if (rand_bp) begin bus.out_ready = ($urandom_range(0, 3) != 0); #1; end
    acc = reset_n && bus.in_valid && bus.in_ready;
    drn = reset_n && bus.out_valid && bus.out_ready;
    if (drn) begin
      chk("out_pending", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("result", bus.result, e.res);
        chk("write_rd", bus.write_rd, e.wr);
        chk("nzcv", bus.nzcv, e.nzcv);
        drains++;
      end
    end
    if (acc) begin
      model_op(bus.opcode, bus.s_bit, bus.op_a, bus.op_b, bus.shift_type, bus.shift_amt,
               bus.shift_by_reg, bus.imm_valid, bus.imm_carry, mflags, r, w);
      sbq.push_back({r, w, mflags});
    end
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [3:0] op, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] st, input logic [7:0] amt,
                        input bit byreg, input bit imm, input bit icarry);
    bus.opcode = op; bus.s_bit = s; bus.op_a = a; bus.op_b = b;
    bus.shift_type = st; bus.shift_amt = amt; bus.shift_by_reg = byreg;
    bus.imm_valid = imm; bus.imm_carry = icarry; bus.in_valid = 1'b1;
  endtask

  task automatic wait_accept(output int lows);
    bit a = 1'b0;
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      tick(a);
      if (a) break;
      lows++;
    end
    chk("accept_in_time", a, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res, input bit wr,
                            input logic [3:0] nz);
    bit a;
    for (int k = 0; k < 20; k++) begin
      if (bus.out_valid) break;
      tick(a);
    end
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_result"}, bus.result, res);
    chk({tag, "_write_rd"}, bus.write_rd, wr);
    chk({tag, "_nzcv"}, bus.nzcv, nz);
  endtask

  task automatic drain();
    bit a;
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sbq.size() == 0 && !bus.out_valid) break;
      tick(a);
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    int lows, d0;
    bit a;
    logic [7:0] amt_tbl [8];
    amt_tbl = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd255, 8'd64, 8'd16};

    reset_n = 1'b0; mflags = 4'b0000;
    bus.out_ready = 1'b1;
    set_op(4'd0, 1'b0, 32'd0, 32'd0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick(a); tick(a);
    reset_n = 1'b1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_write_rd", bus.write_rd, 0);
    chk("rst_nzcv", bus.nzcv, 4'b0000);
    chk("rst_in_ready", bus.in_ready, 1);

    // ADDS overflow with 2-cycle latency
    set_op(4'd4, 1'b1, 32'h7FFF_FFFF, 32'h1, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    chk("adds_lat1_valid", bus.out_valid, 0);
    tick(a);
    chk("adds_lat2_valid", bus.out_valid, 1);
    chk("adds_result", bus.result, 32'h8000_0000);
    chk("adds_nzcv", bus.nzcv, 4'b1001);

    set_op(4'd2, 1'b1, 32'd5, 32'd5, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    expect_out("subs", 32'h0, 1'b1, 4'b0110);

    // Register LSR boundaries and RRX
    set_op(4'd13, 1'b1, 32'd0, 32'h8000_0000, 2'b01, 8'd33, 1'b1, 1'b0, 1'b0);
    wait_accept(lows);
    expect_out("lsr33", 32'h0, 1'b1, 4'b0100);
    set_op(4'd13, 1'b1, 32'd0, 32'h8000_0000, 2'b01, 8'd32, 1'b1, 1'b0, 1'b0);
    wait_accept(lows);
    expect_out("lsr32", 32'h0, 1'b1, 4'b0110);
    set_op(4'd13, 1'b1, 32'd0, 32'h1, 2'b11, 8'd0, 1'b0, 1'b0, 1'b0);
    wait_accept(lows);
    expect_out("rrx", 32'h8000_0000, 1'b1, 4'b1010);

    // Compare/test forms
    set_op(4'd10, 1'b0, 32'd3, 32'd7, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    expect_out("cmp", 32'hFFFF_FFFC, 1'b0, 4'b1000);
    set_op(4'd4, 1'b1, 32'h7FFF_FFFF, 32'h1, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    expect_out("adds_v", 32'h8000_0000, 1'b1, 4'b1001);
    set_op(4'd8, 1'b0, 32'h0F, 32'hF0, 2'b00, 8'd4, 1'b0, 1'b0, 1'b0);
    wait_accept(lows);
    expect_out("tst", 32'h0, 1'b0, 4'b0101);

    // Flag hazard: ADDS then dependent ADC
    set_op(4'd4, 1'b1, 32'hFFFF_FFFF, 32'h1, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    set_op(4'd5, 1'b0, 32'd0, 32'd0, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    chk("hazard_ready_low_cycles", lows, 1);
    expect_out("adc", 32'h1, 1'b1, 4'b0110);
    drain();

    // Backpressure: three ops, out_ready low for four edges
    d0 = drains;
    bus.out_ready = 1'b0;
    set_op(4'd4, 1'b0, 32'd1, 32'h10, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    set_op(4'd4, 1'b0, 32'd2, 32'h20, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    chk("no_stall_without_s", lows, 0);
    set_op(4'd4, 1'b0, 32'd3, 32'h30, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick(a);
      chk("bp_no_accept", a, 0);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_hold_result", bus.result, 32'h11);
    end
    bus.out_ready = 1'b1;
    wait_accept(lows);
    drain();
    chk("bp_result_count", drains - d0, 3);

    // Reset mid-stream discards in-flight work
    bus.out_ready = 1'b0;
    set_op(4'd4, 1'b1, 32'h7FFF_FFFF, 32'h1, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    set_op(4'd12, 1'b0, 32'h5, 32'hA, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0);
    wait_accept(lows);
    reset_n = 1'b0;
    tick(a); tick(a);
    reset_n = 1'b1;
    sbq.delete();
    mflags = 4'b0000;
    bus.out_ready = 1'b1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_nzcv", bus.nzcv, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      tick(a);
      chk("mid_rst_no_stale", bus.out_valid, 0);
    end

    // Randomized stream with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom(),
             ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : $urandom(),
             2'($urandom_range(0, 3)),
             ($urandom_range(0, 1) == 0) ? amt_tbl[$urandom_range(0, 7)] : 8'($urandom()),
             1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)));
      wait_accept(lows);
      repeat ($urandom_range(0, 2)) tick(a);
    end
    drain();
    chk("final_out_valid", bus.out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
